mem_arbiter: RTL

Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU (multicycle controller/datapath) and a DMA/loader port. Each access is sequenced by a small FSM with configurable read latency; requesters use a req/ack handshake, and the CPU's controller holds its current state until `cpu_ack`. Sits between the core's memory interface and the memory array.

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/arb_pick.sv | 13 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encoding and requester ids shared by mem_arbiter and arb_pick
package mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select between CPU and DMA, ties go to the one that did not win last
module arb_pick import mem_arbiter_pkg::*; (
   input  logic cpu_req,
   input  logic dma_req,
   input  logic last,
   output logic grant_id,
   output logic valid
);
   always_comb begin
      valid = cpu_req | dma_req;
      grant_id = (cpu_req & dma_req) ? ~last : (dma_req ? REQ_DMA : REQ_CPU);
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: req/ack arbiter sharing one memory between CPU and DMA with LAT-cycle reads.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          grant,
   output logic          busy
);
   state_t state;
   logic [1:0] cnt;
   logic [DW-1:0] rd_q;
   logic pick_id, pick_valid, last, sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
`ifdef MEM_ARBITER_RR_EN
   logic ptr;
   assign last = ptr;
`else
   assign last = REQ_DMA;
`endif
   arb_pick u_pick (
      .cpu_req(cpu_req),
      .dma_req(dma_req),
      .last(last),
      .grant_id(pick_id),
      .valid(pick_valid)
   );
   assign cpu_rdata = rd_q;
   assign dma_rdata = rd_q;
   always_comb begin
      sel_we = pick_id ? dma_we : cpu_we;
      sel_addr = pick_id ? dma_addr : cpu_addr;
      sel_wdata = pick_id ? dma_wdata : cpu_wdata;
   end
   // mem_* registers double as the latched request while in ACCESS
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         rd_q <= '0;
         grant <= 1'b0;
         busy <= 1'b0;
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
`ifdef MEM_ARBITER_RR_EN
         ptr <= REQ_DMA;
`endif
      end else
         case (state)
            IDLE:
               if (pick_valid) begin
                  state <= ACCESS;
                  grant <= pick_id;
                  busy <= 1'b1;
                  mem_en <= 1'b1;
                  mem_we <= sel_we;
                  mem_addr <= sel_addr;
                  mem_wdata <= sel_wdata;
`ifdef MEM_ARBITER_RR_EN
                  ptr <= pick_id;
`endif
               end
            ACCESS: begin
               state <= mem_we ? DONE : WAIT;
               cnt <= 2'(LAT - 1);
               cpu_ack <= mem_we & ~grant;
               dma_ack <= mem_we & grant;
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               mem_addr <= '0;
               mem_wdata <= '0;
            end
            WAIT:
               if (cnt == 2'd0) begin
                  state <= DONE;
                  rd_q <= mem_rdata;
                  cpu_ack <= ~grant;
                  dma_ack <= grant;
               end else
                  cnt <= cnt - 2'd1;
            DONE: begin
               state <= IDLE;
               busy <= 1'b0;
               cpu_ack <= 1'b0;
               dma_ack <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule
